// File: rtl/obc_dft_pkg.sv
// Shared types and constants for the OBC distributed-arithmetic DFT bin engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package obc_dft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OFFS = 2'd2,
        DONE = 2'd3
    } state_e;

    // Coefficient format of table entries: Q10.21 signed
    localparam int FRAC_BITS = 21;
    localparam int INT_BITS  = 10;

    // Table address map for an n-point engine
    localparam int REAL_BASE = 0;

    function automatic int imag_base(input int n);
        return n;
    endfunction

    function automatic int offs_re_addr(input int n);
        return 2 * n;
    endfunction

    function automatic int offs_im_addr(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/obc_pair_sum.sv
// Forms one bit-plane term D_b: per sample pair, pick E[p][x0^x1] and add or subtract it by x0.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the current bit slice.
module obc_pair_sum
    import obc_dft_pkg::*;
#(
    parameter int N      = 16,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 52
) (
    input  logic [N-1:0]              bits,
    input  logic [N*COEF_W-1:0]       tab,
    output logic signed [ACC_W-1:0]   d
);

    logic [COEF_W-1:0]        e;
    logic signed [ACC_W-1:0]  e_ext;

    // Signed pair lookup and summation over all N/2 pairs
    always_comb begin
        d     = '0;
        e     = '0;
        e_ext = '0;
        for (int p = 0; p < N / 2; p++) begin
            e     = (bits[2*p] ^ bits[2*p+1]) ? tab[(2*p+1)*COEF_W +: COEF_W]
                                              : tab[(2*p)*COEF_W +: COEF_W];
            e_ext = {{(ACC_W-COEF_W){e[COEF_W-1]}}, e};
            d     = bits[2*p] ? (d + e_ext) : (d - e_ext);
        end
    end

endmodule

// File: rtl/obc_dft_bin_engine.sv
// Bit-serial OBC distributed-arithmetic engine producing one complex DFT bin from N real samples.
// Latency: result valid DATA_W+1 cycles after the input handshake edge; one IDLE cycle between vectors.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE. Macro OBC_DFT_SAT_EN selects saturating narrowing.
module obc_dft_bin_engine
    import obc_dft_pkg::*;
#(
    parameter int N      = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 32,
    parameter int ACC_W  = COEF_W + DATA_W + $clog2(N),
    parameter int SHIFT  = 0,
    parameter int OUT_W  = ACC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(2*N+2)-1:0]     cfg_addr,
    input  logic [COEF_W-1:0]            cfg_wdata,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*DATA_W-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_re,
    output logic [OUT_W-1:0]             out_im,
    output logic                         busy
);

    localparam int AW    = $clog2(2*N+2);
    localparam int IW    = $clog2(N);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [AW-1:0] A_IMAG    = AW'(imag_base(N));
    localparam logic [AW-1:0] A_OFFS_RE = AW'(offs_re_addr(N));
    localparam logic [AW-1:0] A_OFFS_IM = AW'(offs_im_addr(N));

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt;
    logic [N*DATA_W-1:0]      samp;
    logic [N-1:0]             bits;
    logic [N*COEF_W-1:0]      tab_re, tab_im;
    logic [COEF_W-1:0]        off_re, off_im;
    logic [IW-1:0]            re_idx, im_idx;
    logic                     first_bit;

    logic signed [ACC_W-1:0]  acc_re, acc_im;
    logic signed [ACC_W-1:0]  d_re, d_im;
    logic signed [ACC_W-1:0]  sum_re, sum_im;
    logic signed [ACC_W-1:0]  sh_re, sh_im;
    logic [OUT_W-1:0]         nar_re, nar_im;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = ACC;
            end
            ACC: begin
                if (bit_cnt == '0) state_d = OFFS;
            end
            OFFS: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Table addresses are below N (real) or 2N (imag) when used, so low bits suffice
    assign re_idx = cfg_addr[IW-1:0];
    assign im_idx = IW'(cfg_addr - A_IMAG);

    // Runtime table loading; only honoured while idle so a running vector sees a fixed table
    always_ff @(posedge clk) begin
        if (rst) begin
            tab_re <= '0;
            tab_im <= '0;
            off_re <= '0;
            off_im <= '0;
        end else if (cfg_we && (state_q == IDLE)) begin
            if (cfg_addr < A_IMAG)
                tab_re[re_idx*COEF_W +: COEF_W] <= cfg_wdata;
            else if (cfg_addr < A_OFFS_RE)
                tab_im[im_idx*COEF_W +: COEF_W] <= cfg_wdata;
            else if (cfg_addr == A_OFFS_RE)
                off_re <= cfg_wdata;
            else if (cfg_addr == A_OFFS_IM)
                off_im <= cfg_wdata;
        end
    end

    // Current bit plane: samples are shifted left each ACC cycle, so the MSB is always bit b
    always_comb begin
        bits = '0;
        for (int n = 0; n < N; n++) bits[n] = samp[n*DATA_W + DATA_W - 1];
    end

    obc_pair_sum #(.N(N), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_pair_re (
        .bits (bits),
        .tab  (tab_re),
        .d    (d_re)
    );

    obc_pair_sum #(.N(N), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_pair_im (
        .bits (bits),
        .tab  (tab_im),
        .d    (d_im)
    );

    // The sign bit plane carries negative weight in two's complement
    assign first_bit = (bit_cnt == CNT_W'(DATA_W - 1));

    assign sum_re = acc_re + {{(ACC_W-COEF_W){off_re[COEF_W-1]}}, off_re};
    assign sum_im = acc_im + {{(ACC_W-COEF_W){off_im[COEF_W-1]}}, off_im};
    assign sh_re  = sum_re >>> SHIFT;
    assign sh_im  = sum_im >>> SHIFT;

    generate
`ifdef OBC_DFT_SAT_EN
        if (OUT_W < ACC_W) begin : g_sat
            function automatic logic [OUT_W-1:0] sat_narrow(input logic signed [ACC_W-1:0] v);
                logic [ACC_W-OUT_W:0] top;
                top = v[ACC_W-1:OUT_W-1];
                if ((top == '0) || (top == '1)) return v[OUT_W-1:0];
                else if (v[ACC_W-1])            return {1'b1, {(OUT_W-1){1'b0}}};
                else                            return {1'b0, {(OUT_W-1){1'b1}}};
            endfunction

            // Clamp the shifted result into the signed OUT_W range
            always_comb begin
                nar_re = sat_narrow(sh_re);
                nar_im = sat_narrow(sh_im);
            end
        end else begin : g_ext
            assign nar_re = OUT_W'(sh_re);
            assign nar_im = OUT_W'(sh_im);
        end
`else
        begin : g_wrap
            // Size cast keeps the low bits when narrowing and sign-extends when widening
            assign nar_re = OUT_W'(sh_re);
            assign nar_im = OUT_W'(sh_im);
        end
`endif
    endgenerate

    // Sample capture, MSB-first shift-accumulate, offset add and output registering
    always_ff @(posedge clk) begin
        if (rst) begin
            samp    <= '0;
            bit_cnt <= '0;
            acc_re  <= '0;
            acc_im  <= '0;
            out_re  <= '0;
            out_im  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        samp    <= in_data;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                        acc_re  <= '0;
                        acc_im  <= '0;
                    end
                end
                ACC: begin
                    acc_re  <= (acc_re <<< 1) + (first_bit ? -d_re : d_re);
                    acc_im  <= (acc_im <<< 1) + (first_bit ? -d_im : d_im);
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    for (int n = 0; n < N; n++)
                        samp[n*DATA_W +: DATA_W] <= {samp[n*DATA_W +: DATA_W-1], 1'b0};
                end
                OFFS: begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    out_re <= nar_re;
                    out_im <= nar_im;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_obc_dft_bin_engine.sv
// Self-checking bench: full-width engine plus a 32-bit-output twin sharing all inputs.
// Expected bins come from a direct dot product of the chosen coefficients and samples.
// Results are scoreboarded in order and compared at each output handshake.
`timescale 1ns/1ps
module tb_obc_dft_bin_engine;

    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int CW   = 32;
    localparam int AW   = $clog2(2*N+2);
    localparam int ACCW = CW + DW + $clog2(N);
    localparam int OW2  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [CW-1:0]     cfg_wdata;
    logic              in_valid;
    logic [N*DW-1:0]   in_data;
    logic              out_ready;
    logic              in_ready, out_valid, busy;
    logic [ACCW-1:0]   out_re, out_im;
    logic              in_ready2, out_valid2, busy2;
    logic [OW2-1:0]    out_re2, out_im2;

    obc_dft_bin_engine #(.N(N), .DATA_W(DW), .COEF_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .busy(busy)
    );

    obc_dft_bin_engine #(.N(N), .DATA_W(DW), .COEF_W(CW), .SHIFT(0), .OUT_W(OW2)) dut32 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_re(out_re2), .out_im(out_im2),
        .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint re;
        longint im;
    } exp_t;

    exp_t   sb[$];
    longint c_re[N];
    longint c_im[N];
    int     xs[N];
    int     acc_cyc, valid_cyc, hs_cyc;

    function automatic logic [N*DW-1:0] pack_xs();
        logic [N*DW-1:0] v;
        v = '0;
        for (int n = 0; n < N; n++) v[n*DW +: DW] = DW'(xs[n]);
        return v;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.re = 0;
        e.im = 0;
        for (int n = 0; n < N; n++) begin
            e.re += c_re[n] * longint'(xs[n]);
            e.im += c_im[n] * longint'(xs[n]);
        end
        return e;
    endfunction

    function automatic logic [31:0] narrow32(input longint v);
        logic [63:0] t;
`ifdef OBC_DFT_SAT_EN
        if (v > 64'sd2147483647)  return 32'h7fff_ffff;
        if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
        t = v;
        return t[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [AW-1:0] a, input logic [CW-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic load_tables();
        longint sr, si;
        sr = 0;
        si = 0;
        for (int p = 0; p < N / 2; p++) begin
            write_cfg(AW'(2*p),       CW'((c_re[2*p] + c_re[2*p+1]) / 2));
            write_cfg(AW'(2*p+1),     CW'((c_re[2*p] - c_re[2*p+1]) / 2));
            write_cfg(AW'(N+2*p),     CW'((c_im[2*p] + c_im[2*p+1]) / 2));
            write_cfg(AW'(N+2*p+1),   CW'((c_im[2*p] - c_im[2*p+1]) / 2));
        end
        for (int n = 0; n < N; n++) begin
            sr += c_re[n];
            si += c_im[n];
        end
        write_cfg(AW'(2*N),   CW'(-sr / 2));
        write_cfg(AW'(2*N+1), CW'(-si / 2));
    endtask

    task automatic send_vec(input logic [N*DW-1:0] data, input bit hold);
        int k;
        in_data  = data;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
        end
        tick();
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic recv_check(input string name);
        int   k;
        exp_t e;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        valid_cyc = cyc;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout: out_valid=%0b required 1 within 100 cycles", name, out_valid);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: queue empty, required one pending result", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (out_re !== ACCW'(e.re)) begin
            errors++;
            $display("FAIL %s_re: got %h required %h", name, out_re, ACCW'(e.re));
        end
        checks++;
        if (out_im !== ACCW'(e.im)) begin
            errors++;
            $display("FAIL %s_im: got %h required %h", name, out_im, ACCW'(e.im));
        end
        checks++;
        if (out_re2 !== narrow32(e.re)) begin
            errors++;
            $display("FAIL %s_re32: got %h required %h", name, out_re2, narrow32(e.re));
        end
        checks++;
        if (out_im2 !== narrow32(e.im)) begin
            errors++;
            $display("FAIL %s_im32: got %h required %h", name, out_im2, narrow32(e.im));
        end
        tick();
        hs_cyc = cyc;
    endtask

    task automatic run_one(input string name);
        sb.push_back(model());
        send_vec(pack_xs(), 1'b0);
        recv_check(name);
        checks++;
        if (valid_cyc - acc_cyc != DW + 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges required %0d", name, valid_cyc - acc_cyc, DW + 1);
        end
    endtask

    task automatic random_coefs();
        for (int n = 0; n < N; n++) begin
            c_re[n] = longint'($urandom_range(0, 1048576)) * 2 - 1048576;
            c_im[n] = longint'($urandom_range(0, 1048576)) * 2 - 1048576;
        end
    endtask

    task automatic random_xs();
        for (int n = 0; n < N; n++) xs[n] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (out_re !== '0)      begin errors++; $display("FAIL reset_out_re: got %h required 0", out_re); end
        checks++; if (out_im !== '0)      begin errors++; $display("FAIL reset_out_im: got %h required 0", out_im); end
    endtask

    task automatic test_sum();
        for (int n = 0; n < N; n++) begin
            c_re[n] = 64'sd2097152;
            c_im[n] = 0;
            xs[n]   = 1;
        end
        load_tables();
        run_one("sum");
    endtask

    task automatic test_cfg_ignore();
        for (int a = 2*N + 2; a < (1 << AW); a++) write_cfg(AW'(a), 32'hDEAD_BEEF);
        run_one("cfg_out_of_range");
    endtask

    task automatic test_impulse();
        for (int n = 0; n < N; n++) begin
            c_re[n] = 0;
            c_im[n] = 0;
            xs[n]   = 0;
        end
        c_re[0] = 64'sd2097152;
        load_tables();
        xs[0] = -32768;
        run_one("impulse_neg");
        xs[0] = 32767;
        run_one("impulse_pos");
    endtask

    task automatic test_random();
        random_coefs();
        load_tables();
        for (int v = 0; v < 3; v++) begin
            random_xs();
            run_one("random");
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        random_xs();
        e = model();
        sb.push_back(e);
        out_ready = 1'b0;
        send_vec(pack_xs(), 1'b0);
        for (int k = 0; k < 100 && !out_valid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL bp_valid: got %0b required 1", out_valid); end
            checks++; if (out_re !== ACCW'(e.re)) begin errors++; $display("FAIL bp_re_hold: got %h required %h", out_re, ACCW'(e.re)); end
            checks++; if (out_im !== ACCW'(e.im)) begin errors++; $display("FAIL bp_im_hold: got %h required %h", out_im, ACCW'(e.im)); end
            checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL bp_in_ready: got %0b required 0", in_ready); end
            checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL bp_busy: got %0b required 1", busy); end
            if (i == 2) write_cfg('0, 32'h1234_5678);
            else        tick();
        end
        recv_check("bp_release");
        run_one("bp_repeat");
    endtask

    task automatic test_reset_mid();
        random_xs();
        send_vec(pack_xs(), 1'b0);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %0b required 1", in_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %0b required 0", busy); end
        for (int n = 0; n < N; n++) begin
            c_re[n] = 0;
            c_im[n] = 0;
            xs[n]   = 1;
        end
        run_one("midrst_cleared");
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] d1, d2;
        int a2, h1;
        random_coefs();
        load_tables();
        random_xs();
        d1 = pack_xs();
        sb.push_back(model());
        random_xs();
        d2 = pack_xs();
        sb.push_back(model());
        a2 = 0;
        h1 = 0;
        out_ready = 1'b1;
        fork
            begin
                send_vec(d1, 1'b1);
                send_vec(d2, 1'b0);
                a2 = acc_cyc;
            end
            begin
                recv_check("b2b_first");
                h1 = hs_cyc;
                recv_check("b2b_second");
            end
        join
        checks++;
        if (a2 != h1 + 1) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got %0d required %0d", a2, h1 + 1);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results left, required 0", sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        test_reset();
        test_sum();
        test_cfg_ignore();
        test_impulse();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
